// File: rtl/kernel_pr_start_sched.sv
// kernel_pr_start_sched: start-token scheduler for one PR kernel dataflow region
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   ap_start        level request to launch one iteration, held until ap_ready
//   ap_ready        one-cycle pulse once every start FIFO holds this iteration's token
//   ap_done         level, at least one completed iteration not yet acknowledged
//   ap_continue     acknowledges one completed iteration while ap_done is high
//   ap_idle         nothing in flight, nothing pending, FSM idle
//   sfifo_write     per start-FIFO write strobe
//   sfifo_din       token data, constant all-ones
//   sfifo_full_n    per start-FIFO not-full
//   proc_done       per-process one-cycle completion pulse
//   inflight        iterations issued but not yet completed
module kernel_pr_start_sched #(
    parameter int NUM_PROC     = 4,
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ap_start,
    output logic                ap_ready,
    output logic                ap_done,
    input  logic                ap_continue,
    output logic                ap_idle,
    output logic [NUM_PROC-1:0] sfifo_write,
    output logic [NUM_PROC-1:0] sfifo_din,
    input  logic [NUM_PROC-1:0] sfifo_full_n,
    input  logic [NUM_PROC-1:0] proc_done,
    output logic [CNT_W-1:0]    inflight
);
    localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_INFLIGHT);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE_ISS} state_t;
    state_t                           r_state;
    logic [NUM_PROC-1:0]              r_sent;
    logic [NUM_PROC-1:0][CNT_W-1:0]   r_dcnt;
    logic [CNT_W-1:0]                 r_inflight;
    logic [CNT_W-1:0]                 r_pend;
    logic [NUM_PROC-1:0]              w_inc;
    logic [NUM_PROC-1:0]              w_have;
    logic [NUM_PROC-1:0]              w_sent_nxt;
    logic [CNT_W:0]                   w_load;
    logic                             w_cmpl;
    logic                             w_start;
    always_comb begin
        w_inc  = '0;
        w_have = '0;
        for (int i = 0; i < NUM_PROC; i++) begin
            // a done pulse on a saturated counter is a protocol error and is dropped
            w_inc[i]  = proc_done[i] & (r_dcnt[i] != MAXC);
            w_have[i] = (r_dcnt[i] != '0) | w_inc[i];
        end
    end
    assign w_cmpl      = &w_have;
    // pending-done iterations still occupy a slot so pend_done can never wrap
    assign w_load      = {1'b0, r_inflight} + {1'b0, r_pend};
    assign w_start     = ap_start & (w_load < {1'b0, MAXC});
    assign sfifo_write = (r_state == S_ISSUE) ? (~r_sent & sfifo_full_n) : '0;
    assign w_sent_nxt  = r_sent | sfifo_write;
    assign sfifo_din   = '1;
    assign ap_ready    = (r_state == S_DONE_ISS);
    assign ap_done     = (r_pend != '0);
    assign ap_idle     = (r_state == S_IDLE) & (r_inflight == '0) & (r_pend == '0);
    assign inflight    = r_inflight;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_sent     <= '0;
            r_dcnt     <= '0;
            r_inflight <= '0;
            r_pend     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_ISSUE;
                        r_sent  <= '0;
                    end
                end
                S_ISSUE: begin
                    r_sent <= w_sent_nxt;
                    if (&w_sent_nxt) r_state <= S_DONE_ISS;
                end
                default: r_state <= S_IDLE;
            endcase
            for (int i = 0; i < NUM_PROC; i++)
                r_dcnt[i] <= r_dcnt[i] + CNT_W'(w_inc[i]) - CNT_W'(w_cmpl);
            r_inflight <= r_inflight + CNT_W'(r_state == S_DONE_ISS) - CNT_W'(w_cmpl);
            r_pend     <= r_pend + CNT_W'(w_cmpl) - CNT_W'(ap_continue && (r_pend != '0));
        end
    end
endmodule

// File: tb/tb_kernel_pr_start_sched.sv
// tb_kernel_pr_start_sched: directed bench for the start-token scheduler
module tb_kernel_pr_start_sched;
    localparam int NP = 4;
    localparam int MI = 4;
    localparam int CW = 4;
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ap_start = 1'b0;
    logic          ap_continue = 1'b0;
    logic          ap_ready;
    logic          ap_done;
    logic          ap_idle;
    logic [NP-1:0] sfifo_write;
    logic [NP-1:0] sfifo_din;
    logic [NP-1:0] sfifo_full_n = '1;
    logic [NP-1:0] proc_done = '0;
    logic [CW-1:0] inflight;
    int            n_chk = 0;
    int            n_bad = 0;
    int            exp_q[$];
    kernel_pr_start_sched #(.NUM_PROC(NP), .MAX_INFLIGHT(MI), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_continue(ap_continue), .ap_idle(ap_idle),
        .sfifo_write(sfifo_write), .sfifo_din(sfifo_din),
        .sfifo_full_n(sfifo_full_n), .proc_done(proc_done), .inflight(inflight)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(negedge clk);
        #1;
    endtask
    // Launch one iteration from an idle FSM; full_n = bp_mask until cycle nbp.
    task automatic run_issue(input logic [NP-1:0] bp_mask, input int nbp, input int exp_lat,
                             input logic [NP-1:0] exp_first, input logic [NP-1:0] pd);
        int            cnt[NP];
        logic [NP-1:0] first;
        int            lat;
        bit            got;
        exp_q.push_back(exp_lat);
        for (int i = 0; i < NP; i++) cnt[i] = 0;
        first = '0;
        lat = 0;
        got = 1'b0;
        ap_start = 1'b1;
        sfifo_full_n = (nbp > 0) ? bp_mask : '1;
        for (int k = 1; k <= 30 && !got; k++) begin
            @(negedge clk);
            if (k == nbp) sfifo_full_n = '1;
            #1;
            if (k == 1) first = sfifo_write;
            for (int i = 0; i < NP; i++) cnt[i] += 32'(sfifo_write[i]);
            if (ap_ready) begin
                got = 1'b1;
                lat = k;
                ap_start = 1'b0;
                proc_done = pd;
            end
        end
        ap_start = 1'b0;
        chk("ready_seen", 32'(got), 32'd1);
        chk("ready_latency", 32'(lat), 32'(exp_q.pop_front()));
        chk("first_issue_writes", 32'(first), 32'(exp_first));
        for (int i = 0; i < NP; i++) chk("token_once", 32'(cnt[i]), 32'd1);
    endtask
    initial begin
        logic [NP-1:0] acc;
        int            rdy;
        int            order[4];
        order = '{0, 2, 1, 3};
        repeat (3) step();
        reset = 1'b0;
        chk("rst_idle", 32'(ap_idle), 32'd1);
        chk("rst_ready", 32'(ap_ready), 32'd0);
        chk("rst_done", 32'(ap_done), 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        chk("rst_write", 32'(sfifo_write), 32'd0);
        chk("din_ones", 32'(sfifo_din), 32'hF);
        // single iteration, no backpressure
        run_issue(4'hF, 0, 2, 4'hF, 4'h0);
        step();
        chk("single_inflight", 32'(inflight), 32'd1);
        chk("single_idle", 32'(ap_idle), 32'd0);
        chk("single_no_write", 32'(sfifo_write), 32'd0);
        // staggered backpressure
        run_issue(4'b1010, 5, 6, 4'b1010, 4'h0);
        step();
        chk("bp_inflight", 32'(inflight), 32'd2);
        // completion ordering 0,2,1,3
        for (int j = 0; j < 4; j++) begin
            proc_done = NP'(1) << order[j];
            chk("done_before_last", 32'(ap_done), 32'd0);
            step();
            proc_done = '0;
        end
        chk("done_rise", 32'(ap_done), 32'd1);
        chk("done_inflight", 32'(inflight), 32'd1);
        ap_continue = 1'b1;
        step();
        ap_continue = 1'b0;
        chk("cont_clear", 32'(ap_done), 32'd0);
        chk("not_idle_yet", 32'(ap_idle), 32'd0);
        proc_done = '1;
        step();
        proc_done = '0;
        chk("done2_rise", 32'(ap_done), 32'd1);
        chk("done2_inflight", 32'(inflight), 32'd0);
        ap_continue = 1'b1;
        step();
        ap_continue = 1'b0;
        chk("back_idle", 32'(ap_idle), 32'd1);
        // in-flight limit
        for (int j = 0; j < MI; j++) begin
            run_issue(4'hF, 0, 2, 4'hF, 4'h0);
            step();
        end
        chk("limit_inflight", 32'(inflight), 32'(MI));
        ap_start = 1'b1;
        acc = '0;
        rdy = 0;
        for (int j = 0; j < 8; j++) begin
            step();
            acc |= sfifo_write;
            rdy += 32'(ap_ready);
        end
        proc_done = '1;
        step();
        proc_done = '0;
        acc |= sfifo_write;
        chk("limit_after_cmpl_inflight", 32'(inflight), 32'(MI - 1));
        chk("limit_pend", 32'(ap_done), 32'd1);
        for (int j = 0; j < 3; j++) begin
            step();
            acc |= sfifo_write;
            rdy += 32'(ap_ready);
        end
        chk("limit_no_write", 32'(acc), 32'd0);
        chk("limit_no_ready", 32'(rdy), 32'd0);
        ap_continue = 1'b1;
        step();
        ap_continue = 1'b0;
        run_issue(4'hF, 0, 2, 4'hF, 4'h0);
        step();
        chk("fifth_inflight", 32'(inflight), 32'(MI));
        // simultaneous DONE_ISS + completion, then completion + continue
        proc_done = '1;
        step();
        proc_done = '0;
        ap_continue = 1'b1;
        step();
        ap_continue = 1'b0;
        chk("pre_sim_inflight", 32'(inflight), 32'd3);
        run_issue(4'hF, 0, 2, 4'hF, 4'hF);
        step();
        proc_done = '0;
        chk("sim_iss_inflight", 32'(inflight), 32'd3);
        chk("sim_iss_done", 32'(ap_done), 32'd1);
        for (int j = 0; j < 3; j++) begin
            proc_done = '1;
            ap_continue = 1'b1;
            step();
            proc_done = '0;
            ap_continue = 1'b0;
            chk("sim_cont_done", 32'(ap_done), 32'd1);
            chk("sim_cont_inflight", 32'(inflight), 32'(2 - j));
        end
        ap_continue = 1'b1;
        step();
        ap_continue = 1'b0;
        chk("sim_final_idle", 32'(ap_idle), 32'd1);
        // reset during ISSUE with two of four tokens sent
        run_issue(4'hF, 0, 2, 4'hF, 4'h0);
        step();
        chk("pre_rst_inflight", 32'(inflight), 32'd1);
        ap_start = 1'b1;
        sfifo_full_n = 4'b0011;
        step();
        chk("partial_write", 32'(sfifo_write), 32'b0011);
        step();
        reset = 1'b1;
        ap_start = 1'b0;
        step();
        reset = 1'b0;
        chk("mid_rst_idle", 32'(ap_idle), 32'd1);
        chk("mid_rst_inflight", 32'(inflight), 32'd0);
        chk("mid_rst_done", 32'(ap_done), 32'd0);
        sfifo_full_n = '1;
        acc = '0;
        for (int j = 0; j < 5; j++) begin
            step();
            acc |= sfifo_write;
        end
        chk("mid_rst_no_write", 32'(acc), 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
